sqrt_iter_unit: RTL and testbench
=================================

// Module: sqrt_iter_unit
// PURPOSE
//   Parametrised iterative integer square root: accepts an unsigned WIDTH-bit radicand,
//   returns floor(sqrt(x)) and remainder x - root^2. Controller and datapath in one block,
//   digit-by-digit (restoring, 2 radicand bits per iteration), UNROLL iterations per clock.
//   Sits behind a valid/ready producer and in front of a valid/ready consumer with backpressure.
// PARAMETERS
//   WIDTH   8  radicand width; must be even and >= 4
//   UNROLL  1  iterations per clock; must divide WIDTH/2 (1, 2, 4, ...)
// PORTS
//   clk_i        in   1          clock, rising edge
//   rst_i        in   1          asynchronous reset, active-high
//   in_valid_i   in   1          radicand valid
//   in_ready_o   out  1          unit can accept radicand (high only in IDLE)
//   x_i          in   WIDTH      unsigned radicand
//   out_valid_o  out  1          result valid (high only in DONE)
//   out_ready_i  in   1          consumer accepts result
//   root_o       out  WIDTH/2    floor(sqrt(x))
//   rem_o        out  WIDTH/2+1  x - root_o^2 (max 2*root_o)
//   exact_o      out  1          rem_o == 0
//   busy_o       out  1          state != IDLE
// BEHAVIOUR
//   Reset (rst_i high, any time, mid-operation included): state IDLE, in_ready_o=1,
//     out_valid_o=0, busy_o=0, root_o=0, rem_o=0, exact_o=1, iteration counter 0.
//     In-flight operation is discarded; no output is produced for it.
//   States: IDLE -> CALC on in_valid_i&in_ready_o; CALC -> DONE after N=WIDTH/(2*UNROLL)
//     cycles; DONE -> IDLE on out_ready_i; DONE holds otherwise.
//   Accept (edge T0): load x shift reg <= x_i, rem <= 0, root <= 0, counter <= N-1.
//   Each CALC cycle performs UNROLL iterations combinationally, per iteration:
//     rem' = (rem<<2) | x[WIDTH-1:WIDTH-2]; x <<= 2; trial = (root<<2)|1;
//     if rem' >= trial: rem = rem'-trial, root = (root<<1)|1; else rem = rem', root = root<<1.
//   Internal rem and trial are WIDTH/2+2 bits; no truncation may occur.
//   Counter decrements each CALC cycle; last CALC cycle (counter==0) moves to DONE.
//   Latency: out_valid_o rises N clock edges after the accepting edge (WIDTH=8,UNROLL=1: 4).
//   root_o/rem_o/exact_o are registered, updated only on entering DONE; stable while
//     out_valid_o=1 and held after the output handshake until the next result.
//   in_ready_o is 0 in CALC and DONE; in_valid_i there is ignored (producer must hold).
//   in_valid_i may stay high across results; no combinational path in_valid_i->out_valid_o.
//   Output handshake and new input never overlap: min initiation interval N+2 cycles
//     (accept, N CALC, DONE with out_ready_i=1, back in IDLE).
//   out_ready_i sampled only in DONE; high before DONE has no effect.
//   x_i=0 -> root 0, rem 0, exact 1; x_i=all-ones -> root 2^(WIDTH/2)-1, rem 2*root.
//   Unreachable state encodings return to IDLE next cycle with outputs as IDLE.
// TESTING
//   WIDTH=8: reset, x_i=0 accepted -> after 4 edges out_valid_o=1, root 0, rem 0, exact 1.
//   WIDTH=8: x_i=200 -> root 14, rem 4, exact 0; x_i=144 -> root 12, rem 0, exact 1.
//   WIDTH=16,UNROLL=2: x_i=65535 -> latency 4, root 255, rem 510; x_i=1 -> root 1, rem 0.
//   Backpressure: out_ready_i low 10 cycles in DONE -> out_valid_o/root_o stable,
//     in_ready_o=0 throughout, held in_valid_i not accepted until after output handshake.
//   rst_i asserted on 2nd CALC cycle -> immediately IDLE, busy_o=0, out_valid_o=0, no result.
//   Random sweep all 2^WIDTH inputs (WIDTH=8, UNROLL 1/2/4) vs reference model, random ready.

Source files
------------

// File: rtl/sqrt_iter_unit_if.sv
// Handshake bundle for the iterative square-root unit: radicand in, root/remainder out.
// The slave modport is the unit's view; the master modport is the producer/consumer side.
interface sqrt_iter_unit_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     x_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [WIDTH/2-1:0]   root_o;
    logic [WIDTH/2:0]     rem_o;
    logic                 exact_o;
    logic                 busy_o;

    modport slave (
        input  in_valid_i, x_i, out_ready_i,
        output in_ready_o, out_valid_o, root_o, rem_o, exact_o, busy_o
    );

    modport master (
        output in_valid_i, x_i, out_ready_i,
        input  in_ready_o, out_valid_o, root_o, rem_o, exact_o, busy_o
    );
endinterface

// File: rtl/sqrt_iter_unit.sv
// Restoring digit-by-digit integer sqrt, UNROLL iterations per clock; result valid N=WIDTH/(2*UNROLL)
// edges after accept. Accepts only in IDLE; DONE holds the result until out_ready_i.
module sqrt_iter_unit #(
    parameter int WIDTH  = 8,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    sqrt_iter_unit_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int RW = H + 2;
    localparam int N  = WIDTH / (2 * UNROLL);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] x_q;
    logic [RW-1:0]    rem_q;
    logic [H-1:0]     root_q;
    logic [CW-1:0]    cnt_q;
    logic [H-1:0]     root_out_q;
    logic [H:0]       rem_out_q;
    logic             exact_q;

    logic [WIDTH-1:0] nx_x;
    logic [RW-1:0]    nx_rem;
    logic [RW-1:0]    trial;
    logic [H-1:0]     nx_root;

    // Partial remainder stays below 2^H before every non-final step, so dropping
    // its top two bits on the shift never loses information.
    always_comb begin
        nx_x    = x_q;
        nx_rem  = rem_q;
        nx_root = root_q;
        trial   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            nx_rem = {nx_rem[RW-3:0], nx_x[WIDTH-1 -: 2]};
            nx_x   = nx_x << 2;
            trial  = {nx_root, 2'b01};
            if (nx_rem >= trial) begin
                nx_rem  = nx_rem - trial;
                nx_root = {nx_root[H-2:0], 1'b1};
            end else begin
                nx_root = {nx_root[H-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            root_out_q  <= '0;
            rem_out_q   <= '0;
            exact_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        x_q        <= bus.x_i;
                        rem_q      <= '0;
                        root_q     <= '0;
                        cnt_q      <= CW'(N - 1);
                    end
                end
                CALC: begin
                    x_q    <= nx_x;
                    rem_q  <= nx_rem;
                    root_q <= nx_root;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        root_out_q  <= nx_root;
                        rem_out_q   <= nx_rem[H:0];
                        exact_q     <= (nx_rem == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.root_o      = root_out_q;
    assign bus.rem_o       = rem_out_q;
    assign bus.exact_o     = exact_q;
endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Bench for sqrt_iter_unit: four configurations (8/1, 8/2, 8/4, 16/2) share one stimulus
// port selected by sel; results compared against a brute-force floor-sqrt model.
module tb_sqrt_iter_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] x;
    int          sel;

    logic        in_ready, out_valid, busy, exact;
    logic [7:0]  root;
    logic [8:0]  rem;

    int n_chk  = 0;
    int n_fail = 0;

    int cfg_w[4] = '{8, 8, 8, 16};
    int cfg_u[4] = '{1, 2, 4, 2};

    always #5 clk = ~clk;

    sqrt_iter_unit_if #(.WIDTH(8))  if0 ();
    sqrt_iter_unit_if #(.WIDTH(8))  if1 ();
    sqrt_iter_unit_if #(.WIDTH(8))  if2 ();
    sqrt_iter_unit_if #(.WIDTH(16)) if3 ();

    sqrt_iter_unit #(.WIDTH(8),  .UNROLL(1)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
    sqrt_iter_unit #(.WIDTH(8),  .UNROLL(2)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
    sqrt_iter_unit #(.WIDTH(8),  .UNROLL(4)) u2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));
    sqrt_iter_unit #(.WIDTH(16), .UNROLL(2)) u3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave));

    assign if0.in_valid_i  = in_valid && (sel == 0);
    assign if1.in_valid_i  = in_valid && (sel == 1);
    assign if2.in_valid_i  = in_valid && (sel == 2);
    assign if3.in_valid_i  = in_valid && (sel == 3);
    assign if0.out_ready_i = out_ready && (sel == 0);
    assign if1.out_ready_i = out_ready && (sel == 1);
    assign if2.out_ready_i = out_ready && (sel == 2);
    assign if3.out_ready_i = out_ready && (sel == 3);
    assign if0.x_i = x[7:0];
    assign if1.x_i = x[7:0];
    assign if2.x_i = x[7:0];
    assign if3.x_i = x;

    always_comb begin
        in_ready  = if0.in_ready_o;
        out_valid = if0.out_valid_o;
        busy      = if0.busy_o;
        exact     = if0.exact_o;
        root      = {4'b0, if0.root_o};
        rem       = {4'b0, if0.rem_o};
        case (sel)
            1: begin
                in_ready = if1.in_ready_o; out_valid = if1.out_valid_o; busy = if1.busy_o;
                exact = if1.exact_o; root = {4'b0, if1.root_o}; rem = {4'b0, if1.rem_o};
            end
            2: begin
                in_ready = if2.in_ready_o; out_valid = if2.out_valid_o; busy = if2.busy_o;
                exact = if2.exact_o; root = {4'b0, if2.root_o}; rem = {4'b0, if2.rem_o};
            end
            3: begin
                in_ready = if3.in_ready_o; out_valid = if3.out_valid_o; busy = if3.busy_o;
                exact = if3.exact_o; root = if3.root_o; rem = if3.rem_o;
            end
            default: ;
        endcase
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cfg %0d): got %0d expected %0d", name, sel, act, exp);
        end
    endfunction

    // floor(sqrt) by search: largest r with r*r <= x
    function automatic void ref_sqrt(input int xv, output int r, output int m);
        r = 0;
        while ((r + 1) * (r + 1) <= xv) r++;
        m = xv - r * r;
    endfunction

    function automatic int lat_of(int c);
        return cfg_w[c] / (2 * cfg_u[c]);
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_root"},      root,      0);
        chk({tag, "_rem"},       rem,       0);
        chk({tag, "_exact"},     exact,     1);
    endtask

    // Called #1 after a rising edge with the selected unit idle.
    task automatic run_one(input int xv, input int er, input int em, input int ee, input int gap);
        int lat;
        x = 16'(xv);
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_calc", busy, 1);
        wait_valid(lat);
        chk("latency", lat, lat_of(sel));
        for (int g = 0; g < gap; g++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_root", root, er);
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("root", root, er);
        chk("rem", rem, em);
        chk("exact", exact, ee);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_root_held", root, er);
    endtask

    typedef struct {
        int cfg;
        int xv;
        int er;
        int em;
        int ee;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   lat, r, m, seen;

        vecs[0] = '{0, 0,     0,   0,   1};
        vecs[1] = '{0, 200,   14,  4,   0};
        vecs[2] = '{0, 144,   12,  0,   1};
        vecs[3] = '{0, 255,   15,  30,  0};
        vecs[4] = '{0, 2,     1,   1,   0};
        vecs[5] = '{3, 65535, 255, 510, 0};
        vecs[6] = '{3, 1,     1,   0,   1};
        vecs[7] = '{2, 99,    9,   18,  0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            sel = c; #1;
            chk_reset_state("reset");
        end
        rst = 1'b0;
        sel = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].cfg; #1;
            run_one(vecs[i].xv, vecs[i].er, vecs[i].em, vecs[i].ee, 0);
        end

        // Backpressure with the producer holding the next radicand
        sel = 0; #1;
        x = 16'd50; in_valid = 1'b1;
        @(posedge clk); #1;
        x = 16'd81;
        wait_valid(lat);
        chk("bp_latency", lat, 4);
        for (int g = 0; g < 10; g++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_root", root, 7);
            chk("bp_rem", rem, 1);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_valid", out_valid, 0);
        chk("bp_hs_busy", busy, 0);
        chk("bp_hs_root_held", root, 7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_busy", busy, 1);
        wait_valid(lat);
        chk("bp_next_latency", lat, 4);
        chk("bp_next_root", root, 9);
        chk("bp_next_exact", exact, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // out_ready held high before DONE must not shorten the operation
        x = 16'd144; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("early_rdy_latency", lat, 4);
        chk("early_rdy_root", root, 12);
        @(posedge clk); #1;
        chk("early_rdy_one_cycle", out_valid, 0);
        out_ready = 1'b0;

        // Reset on the second CALC cycle discards the operation
        x = 16'd200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk_reset_state("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_result", seen, 0);
        chk("midrst_idle", in_ready, 1);

        for (int c = 0; c < 3; c++) begin
            sel = c; #1;
            for (int xv = 0; xv < 256; xv++) begin
                ref_sqrt(xv, r, m);
                run_one(xv, r, m, (m == 0) ? 1 : 0, int'($urandom_range(0, 3)));
            end
        end
        sel = 3; #1;
        for (int k = 0; k < 200; k++) begin
            int xv;
            xv = int'($urandom_range(0, 65535));
            ref_sqrt(xv, r, m);
            run_one(xv, r, m, (m == 0) ? 1 : 0, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
